dla_hld_ram_read_streamer: RTL and testbench

Read-side controller for an MLAB/M20K simple-dual-port RAM instance: accepts a valid/ready stream of read addresses, drives the RAM's port-b read interface, and returns read data on a valid/ready response stream. Absorbs the RAM's fixed 0–2 cycle read latency with a credit-managed output buffer, so backpressure never stalls or drops in-flight reads. Sits between a consumer datapath (e.g. filter/feature fetch) and the RAM wrapper's port b; the writer drives port a independently.

---
 rtl/dla_hld_ram_pkg.sv | 16 +
 rtl/dla_hld_ram_read_streamer_buffer.sv | 60 ++++++
 rtl/dla_hld_ram_read_streamer.sv | 106 ++++++++++
 tb/tb_dla_hld_ram_read_streamer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dla_hld_ram_pkg.sv
// Helpers shared by the HLD RAM wrapper and its read-side streamer so both
// agree on the read latency implied by the port-b register options.
package dla_hld_ram_pkg;

  localparam int MAX_READ_LATENCY = 2;

  function automatic int ram_read_latency(input int reg_addr, input int reg_data);
    return reg_addr + reg_data;
  endfunction

  // Enough slots to cover every in-flight read plus one cycle of pop-to-credit delay.
  function automatic int stream_buf_depth(input int read_latency);
    return read_latency + 2;
  endfunction

endpackage

// File: rtl/dla_hld_ram_read_streamer_buffer.sv
// Small register FIFO for read responses; control is reset, storage is not.
// There is no full-side flow control: the parent guarantees it is never overrun.
module dla_hld_ram_read_streamer_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  // DEPTH is usually not a power of two, so wrap by compare rather than mask.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty_o     = (count_q == '0);
  assign pop_ok      = pop_i & ~empty_o;
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/dla_hld_ram_read_streamer.sv
// Read-side controller for a simple-dual-port RAM: address stream in, data stream
// out, with credits covering the RAM's fixed read latency so backpressure never drops reads.
module dla_hld_ram_read_streamer
  import dla_hld_ram_pkg::*;
#(
  parameter int DEPTH               = 32,
  parameter int WIDTH               = 16,
  parameter int REGISTER_B_ADDRESS  = 1,
  parameter int REGISTER_B_READDATA = 1,
  localparam int ADDR = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDR-1:0]  req_address,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [ADDR-1:0]  ram_b_address,
  output logic             ram_b_read_enable,
  output logic             ram_b_in_clock_en,
  output logic             ram_b_out_clock_en,
  input  logic [WIDTH-1:0] ram_b_readdata
);

  localparam int READ_LATENCY = ram_read_latency(REGISTER_B_ADDRESS, REGISTER_B_READDATA);
  localparam int BUF_DEPTH    = stream_buf_depth(READ_LATENCY);
  localparam int USED_W       = $clog2(BUF_DEPTH + 1);

  logic              accept;
  logic              pop;
  logic              capture;
  logic              buf_empty;
  logic [USED_W-1:0] buf_count;
  logic [USED_W-1:0] used_q, used_d;

  // Ready comes only from the registered credit count, never from rsp_ready.
  assign req_ready = resetn & (used_q < USED_W'(BUF_DEPTH));
  assign accept    = req_valid & req_ready;
  assign rsp_valid = ~buf_empty;
  assign pop       = rsp_valid & rsp_ready;

  assign ram_b_address      = req_address;
  assign ram_b_read_enable  = accept;
  assign ram_b_in_clock_en  = 1'b1;
  assign ram_b_out_clock_en = 1'b1;

  generate
    if (READ_LATENCY == 0) begin : g_no_latency
      assign capture = accept;
    end else begin : g_latency
      logic [READ_LATENCY-1:0] inflight_q, inflight_d;

      assign inflight_d[0] = accept;
      for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
        assign inflight_d[gi] = inflight_q[gi-1];
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          inflight_q <= '0;
        end else begin
          inflight_q <= inflight_d;
        end
      end

      assign capture = inflight_q[READ_LATENCY-1];
    end
  endgenerate

  assign used_d = used_q + USED_W'(accept) - USED_W'(pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      used_q <= '0;
    end else begin
      used_q <= used_d;
    end
  end

  dla_hld_ram_read_streamer_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clock_i     (clock),
    .resetn_i    (resetn),
    .push_i      (capture),
    .push_data_i (ram_b_readdata),
    .pop_i       (pop),
    .empty_o     (buf_empty),
    .count_o     (buf_count),
    .head_data_o (rsp_data)
  );

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (resetn) begin
      assert (!(capture && (buf_count == USED_W'(BUF_DEPTH))));
      assert (used_q <= USED_W'(BUF_DEPTH));
      assert (READ_LATENCY <= MAX_READ_LATENCY);
    end
  end
`endif

endmodule

// File: tb/tb_dla_hld_ram_read_streamer.sv
// Bench for the RAM read streamer: three instances (read latency 0, 1, 2), each
// with its own RAM model, checked by a scoreboard fed on request acceptance.
module tb_dla_hld_ram_read_streamer;

  logic        clk;
  logic        resetn;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [4:0]  req_address [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [15:0] rsp_data [3];
  logic [4:0]  ram_addr [3];
  logic [2:0]  ram_rden;
  logic [2:0]  ram_ince;
  logic [2:0]  ram_outce;
  logic [15:0] ram_rd [3];

  int          n_checks;
  int          n_fail;
  bit          verbose;
  logic [15:0] exp_mem [3][16];
  int          exp_wr [3];
  int          exp_rd [3];

  function automatic logic [15:0] data_of(input logic [4:0] a);
    return (a == 5'd5) ? 16'hBEEF : 16'h1000 + {11'd0, a} * 16'h0111;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int RA = (gi >= 1) ? 1 : 0;
    localparam int RD = (gi >= 2) ? 1 : 0;
    logic [4:0]  addr_q;
    logic [15:0] raw;
    logic [15:0] data_q;

    dla_hld_ram_read_streamer #(
      .DEPTH               (32),
      .WIDTH               (16),
      .REGISTER_B_ADDRESS  (RA),
      .REGISTER_B_READDATA (RD)
    ) u_dut (
      .clock              (clk),
      .resetn             (resetn),
      .req_valid          (req_valid[gi]),
      .req_ready          (req_ready[gi]),
      .req_address        (req_address[gi]),
      .rsp_valid          (rsp_valid[gi]),
      .rsp_ready          (rsp_ready[gi]),
      .rsp_data           (rsp_data[gi]),
      .ram_b_address      (ram_addr[gi]),
      .ram_b_read_enable  (ram_rden[gi]),
      .ram_b_in_clock_en  (ram_ince[gi]),
      .ram_b_out_clock_en (ram_outce[gi]),
      .ram_b_readdata     (ram_rd[gi])
    );

    // RAM model: optional address register, optional read-data register.
    always @(posedge clk) begin
      addr_q <= ram_addr[gi];
      data_q <= raw;
    end
    if (RA == 1) begin : g_ra
      assign raw = data_of(addr_q);
    end else begin : g_na
      assign raw = data_of(ram_addr[gi]);
    end
    if (RD == 1) begin : g_rd
      assign ram_rd[gi] = data_q;
    end else begin : g_nd
      assign ram_rd[gi] = raw;
    end
  end

  // Monitor: pop/compare responses, push expectations on accepted requests.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!resetn) begin
        exp_rd[i] = exp_wr[i];
      end else begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_wr[i] == exp_rd[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp_inst%0d: got %h, required no response", i, rsp_data[i]);
          end else begin
            check($sformatf("rsp_data_inst%0d", i), {16'd0, rsp_data[i]},
                  {16'd0, exp_mem[i][exp_rd[i] % 16]});
            if (verbose) $display("rsp inst %0d data %h", i, rsp_data[i]);
            exp_rd[i]++;
          end
        end
        if (req_valid[i] && req_ready[i]) begin
          exp_mem[i][exp_wr[i] % 16] = data_of(req_address[i]);
          exp_wr[i]++;
        end
        check($sformatf("credit_bound_inst%0d", i), {31'd0, ((exp_wr[i] - exp_rd[i]) <= i + 2)}, 32'd1);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int cyc;
    bit [2:0] took;

    n_checks = 0;
    n_fail   = 0;
    verbose  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_wr[i] = 0;
      exp_rd[i] = 0;
      req_address[i] = '0;
    end
    resetn    = 1'b0;
    req_valid = '0;
    rsp_ready = '0;

    // Reset state
    repeat (3) next_cycle();
    check("ready_in_reset", {29'd0, req_ready}, 32'd0);
    check("rsp_valid_in_reset", {29'd0, rsp_valid}, 32'd0);
    resetn    = 1'b1;
    rsp_ready = 3'b111;
    next_cycle();
    check("ready_after_reset", {29'd0, req_ready}, 32'h7);
    check("rsp_valid_after_reset", {29'd0, rsp_valid}, 32'd0);
    check("ram_clock_en", {26'd0, ram_ince, ram_outce}, 32'h3f);

    // Single read of address 5 on all instances; latency L shows at cycle L+1
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) req_address[i] = 5'd5;
    #1;
    check("single_accept", {29'd0, req_ready}, 32'h7);
    check("single_rden", {29'd0, ram_rden}, 32'h7);
    check("single_addr", {27'd0, ram_addr[2]}, 32'd5);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      req_valid = '0;
      for (int i = 0; i < 3; i++)
        check($sformatf("single_rsp_valid_inst%0d_t%0d", i, k), {31'd0, rsp_valid[i]}, {31'd0, (k == i + 1)});
      if (k == 3) check("single_rsp_data_lat2", {16'd0, rsp_data[2]}, 32'hBEEF);
    end

    // Back-to-back 16 reads: ready never drops, one response per cycle
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) req_address[i] = 5'(k);
        #1;
        check($sformatf("b2b_ready_t%0d", k), {29'd0, req_ready}, 32'h7);
      end else begin
        req_valid = '0;
        #1;
      end
      for (int i = 0; i < 3; i++)
        check($sformatf("b2b_rsp_valid_inst%0d_t%0d", i, k), {31'd0, rsp_valid[i]},
              {31'd0, (k >= i + 1) && (k < 16 + i + 1)});
      next_cycle();
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_drained_inst%0d", i), exp_wr[i] - exp_rd[i], 32'd0);

    // Backpressure on latency-2 instance: exactly 4 accepts
    rsp_ready = 3'b011;
    req_valid = 3'b100;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      req_address[2] = 5'(20 + acc);
      #1;
      check($sformatf("bp_ready_t%0d", k), {31'd0, req_ready[2]}, {31'd0, (k < 4)});
      if (req_ready[2]) acc++;
      next_cycle();
    end
    check("bp_accepts", acc, 32'd4);
    req_valid = '0;
    rsp_ready = 3'b111;
    #1;
    check("bp_ready_at_first_pop", {31'd0, req_ready[2]}, 32'd0);
    check("bp_first_data", {16'd0, rsp_data[2]}, {16'd0, data_of(5'd20)});
    next_cycle();
    check("bp_ready_after_pop", {31'd0, req_ready[2]}, 32'd1);
    repeat (5) next_cycle();
    check("bp_drained", exp_wr[2] - exp_rd[2], 32'd0);

    // Reset with two reads in flight and two buffered
    rsp_ready = 3'b011;
    req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      req_address[2] = 5'(8 + k);
      #1;
      check($sformatf("rst_fill_ready_t%0d", k), {31'd0, req_ready[2]}, 32'd1);
      next_cycle();
    end
    req_valid = '0;
    check("rst_buffered_before", {31'd0, rsp_valid[2]}, 32'd1);
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("rst_rsp_valid_t%0d", k), {29'd0, rsp_valid}, 32'd0);
      check($sformatf("rst_ready_t%0d", k), {29'd0, req_ready}, 32'd0);
      if (k < 2) next_cycle();
    end
    resetn    = 1'b1;
    rsp_ready = 3'b111;
    #1;
    check("rst_ready_after_release", {29'd0, req_ready}, 32'h7);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      check($sformatf("rst_no_stale_t%0d", k), {29'd0, rsp_valid}, 32'd0);
    end

    // Random valid/ready, 10k requests on the latency-2 instance
    verbose = 1'b0;
    acc  = 0;
    cyc  = 0;
    took = '0;
    while (acc < 10000 && cyc < 60000) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || took[i]) begin
          req_valid[i]   = 1'($urandom_range(0, 1));
          req_address[i] = 5'($urandom_range(0, 31));
        end
        rsp_ready[i] = 1'($urandom_range(0, 1));
      end
      #1;
      took = req_valid & req_ready;
      if (took[2]) acc++;
      next_cycle();
      cyc++;
    end
    check("random_accepts", acc, 32'd10000);
    req_valid = '0;
    rsp_ready = 3'b111;
    repeat (10) next_cycle();
    for (int i = 0; i < 3; i++)
      check($sformatf("random_drained_inst%0d", i), exp_wr[i] - exp_rd[i], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
